store_trace_buffer: RTL

// - Downstream neighbour of the single-cycle MIPS top: snoops its data-memory write port (dataadr, writedata, memwrite, pc) every cycle.
// - Queues each store as a trace record in a FIFO and drains records over a valid/ready port.
// - Consumers are a UART/log streamer or the testbench monitor; it replaces per-cycle $display sampling of writedata.
// - Overflow is counted, never stalls the CPU.

---
 rtl/mips_trace_pkg.sv | 31 +++
 rtl/trace_fifo.sv | 58 +++++
 rtl/store_trace_buffer.sv | 77 +++++++
 3 files changed

// File: rtl/mips_trace_pkg.sv
// rtl/mips_trace_pkg.sv - store trace record types and data masking helper
//
// Shared types for the store trace path.
//   memwrite_t  : store kind as driven by the CPU memwrite port
//   store_rec_t : one trace record {kind, addr, data, pc}, 98 bits packed
//   mask_data   : clears the data bits that a half/byte store does not write
package mips_trace_pkg;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_WORD = 2'b01,
    MW_HALF = 2'b10,
    MW_BYTE = 2'b11
  } memwrite_t;

  typedef struct packed {
    memwrite_t   kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } store_rec_t;

  function automatic logic [31:0] mask_data(input memwrite_t kind, input logic [31:0] data);
    case (kind)
      MW_HALF: return {16'h0000, data[15:0]};
      MW_BYTE: return {24'h000000, data[7:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - generic synchronous first-word-fall-through FIFO
//
// Ports:
//   clk, reset     : rising-edge clock, synchronous active-low reset
//   push, din      : write request and data; ignored when full unless popping
//   pop            : discard head; ignored when empty
//   dout           : head entry, combinational from storage
//   full, empty    : occupancy flags, registered-pointer derived only
//   count          : occupancy 0..DEPTH
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  // A pop frees the head slot on the same edge, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; stale contents are never visible because empty masks them.
  always_ff @(posedge clk) begin
    if (reset && do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/store_trace_buffer.sv
// rtl/store_trace_buffer.sv - snoops CPU stores into a drainable trace FIFO
//
// Ports:
//   clk, reset                      : CPU clock, synchronous active-low reset
//   memwrite, dataadr, writedata, pc: CPU data-memory write port (snooped)
//   rec_valid, rec_ready            : head record handshake
//   rec_kind, rec_addr, rec_data, rec_pc : head record fields (data masked)
//   level                           : FIFO occupancy
//   dropped                         : saturating count of stores lost to a full FIFO
module store_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             memwrite,
  input  logic [31:0]            dataadr,
  input  logic [31:0]            writedata,
  input  logic [31:0]            pc,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [1:0]             rec_kind,
  output logic [31:0]            rec_addr,
  output logic [31:0]            rec_data,
  output logic [31:0]            rec_pc,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       dropped
);

  memwrite_t  kind_in;
  store_rec_t rec_in;
  store_rec_t head;
  logic       push;
  logic       full;
  logic       empty;
  logic       drop;

  assign kind_in = memwrite_t'(memwrite);
  assign push    = (kind_in != MW_NONE);
  assign rec_in  = '{kind: kind_in, addr: dataadr, data: mask_data(kind_in, writedata), pc: pc};

  trace_fifo #(
    .WIDTH($bits(store_rec_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (rec_in),
    .pop   (rec_ready),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (level)
  );

  // Valid depends only on registered pointers, never on rec_ready.
  assign rec_valid = !empty;
  assign rec_kind  = head.kind;
  assign rec_addr  = head.addr;
  assign rec_data  = head.data;
  assign rec_pc    = head.pc;

  // Full implies non-empty, so rec_ready alone decides whether the head slot frees up.
  assign drop = push && full && !rec_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dropped <= '0;
    end else if (drop && (dropped != {CNT_W{1'b1}})) begin
      dropped <= dropped + 1'b1;
    end
  end

endmodule
